adc_power_sequencer: RTL and testbench
======================================

Name: adc_power_sequencer

Overview:
Parametrised successor to the ADC power/calibration controller. Sequences ADC and analog supply bring-up, initial register write, calibration, DES enable/disable, sleep/wake and shutdown. Adds configurable delays, calibration and register-write timeouts with a FAULT state, and status outputs. The serial register writer stays external and is driven through a request/done handshake.

Parameters:
- TIMER_W, 24, width of the shared delay/timeout counter.
- ADC_WARM_CYC, 256, cycles in ADC_WARM before analog power is enabled.
- ANA_WARM_CYC, 8388608, cycles in ANA_WARM before the init write (clock settle).
- WAKE_CYC, 128, cycles in WAKE before DES re-enable.
- SHUT_CYC, 256, cycles in SHUTDOWN before ADC power drops.
- TIMEOUT_CYC, 1048576, limit for any wait on InCalRunning or RegWriteDone.
- All cycle parameters must be at least 1 and at most 2^TIMER_W-1.

Ports:
- Clock  in  1  system clock
- Reset  in  1  Reset, synchronous, active-high; clock Clock
- Cmd  in  8  ASCII command byte, valid when NewCmd=1
- NewCmd  in  1  one-cycle command strobe
- OutToADCEnable  in  1  board permits driving the ADC; low forces shutdown
- Sleep  in  1  level request to enter low-power idle
- WakeUp  in  1  level request to leave low-power idle
- InCalRunning  in  1  ADC calibration-busy pin
- RegWriteDone  in  1  one-cycle done pulse from the serial writer
- RegReq  out  1  register-write request, held until done
- RegOp  out  2  0=INIT, 1=DES_ENABLE, 2=DES_DISABLE; stable while RegReq=1
- ADCPower  out  1  ADC supply enable
- AnalogPower  out  1  analog front-end supply enable
- OutCal  out  1  ADC CAL pin
- State  out  4  current state encoding
- Ready  out  1  high in SAMPLING
- Fault  out  1  high in FAULT

Behaviour:
- States: OFF=0, ADC_WARM=1, ANA_WARM=2, INIT_WR=3, INIT_IDLE=4, CAL_REQ=5, CAL=6, DES_EN=7, SAMPLING=8, DIS_SLEEP=9, SLEEP=10, WAKE=11, DIS_CAL=12, SHUTDOWN=13, FAULT=14.
- Reset: state OFF, timer 0. All outputs 0 (RegOp=0, State=0).
- Timer:
  - Clears on every state change and counts +1 per cycle within a state.
  - It is terminal when the count equals the state's parameter minus 1, so a delay state lasts exactly N cycles.
  - The count saturates at its maximum and never wraps.
- Transitions (evaluated in priority order within each state):
  - OFF: "O" -> ADC_WARM.
  - ADC_WARM: terminal -> ANA_WARM.
  - ANA_WARM: terminal -> INIT_WR.
  - INIT_WR: RegWriteDone -> INIT_IDLE; TIMEOUT -> FAULT.
  - INIT_IDLE: "C" -> CAL_REQ.
  - CAL_REQ: InCalRunning -> CAL; TIMEOUT -> FAULT.
  - CAL: ~InCalRunning and "N" -> DES_EN; InCalRunning still high at TIMEOUT -> FAULT. Once calibration has ended, the state waits for "N" with no timeout.
  - DES_EN: RegWriteDone -> SAMPLING; TIMEOUT -> FAULT.
  - SAMPLING: ("o" or ~OutToADCEnable) -> SHUTDOWN; else ("S" or Sleep) -> DIS_SLEEP; else "C" -> DIS_CAL.
  - DIS_SLEEP: RegWriteDone -> SLEEP; TIMEOUT -> FAULT.
  - SLEEP: ("o" or ~OutToADCEnable) -> SHUTDOWN; else ("W" or WakeUp) -> WAKE.
  - WAKE: terminal -> DES_EN.
  - DIS_CAL: RegWriteDone -> CAL_REQ; TIMEOUT -> FAULT.
  - SHUTDOWN: terminal -> OFF.
  - FAULT: "o", ~OutToADCEnable or "O" -> SHUTDOWN.
- Global rule: ~OutToADCEnable in any state other than OFF, ADC_WARM or SHUTDOWN forces SHUTDOWN next cycle. This rule overrides all others.
- Outputs are registered and decoded from the next state, so they change in the same cycle as State:
  - ADCPower = state != OFF.
  - AnalogPower = OutToADCEnable and state not in {OFF, ADC_WARM, SHUTDOWN, FAULT}.
  - OutCal = state == CAL_REQ.
  - RegReq = state in {INIT_WR, DES_EN, DIS_SLEEP, DIS_CAL}.
- Handshake:
  - RegWriteDone is ignored outside write states.
  - RegReq drops in the cycle after done is sampled.
  - A new write state entered directly from another write state (e.g. DIS_CAL -> CAL_REQ is not one) deasserts RegReq for at least one cycle.
- Unrecognised commands and commands received in non-listening states are dropped.

Optional Feature:
AUTO_CAL_EN.
- Defined:
  - INIT_IDLE proceeds to CAL_REQ after WAKE_CYC cycles with no "C" needed.
  - CAL proceeds to DES_EN one cycle after InCalRunning falls, with no "N" needed.
  - Commands "C" and "N" are still accepted and take effect immediately.
- Undefined: command-driven behaviour exactly as in Behaviour above.

Decomposition:
- Shared package adc_seq_pkg holds:
  - the state encoding constants;
  - the RegOp encodings (REGOP_INIT, REGOP_DES_EN, REGOP_DES_DIS);
  - the command byte constants ("O", "o", "C", "N", "S", "W").
- One sub-module, adc_seq_timer: TIMER_W-bit saturating up-counter with a sync clear, plus a compare against a terminal value.

Test Plan:
- Bring-up (ADC_WARM_CYC=4, ANA_WARM_CYC=8): "O" -> ADCPower=1 next cycle; AnalogPower=1 exactly 4 cycles later; RegReq=1, RegOp=0 8 cycles after that; done pulse -> State=4.
- Calibration: "C" in INIT_IDLE -> OutCal=1; InCalRunning high for 10 cycles, then low; "N" -> RegOp=1; done -> Ready=1, State=8.
- Timeout (TIMEOUT_CYC=16): InCalRunning held 0 in CAL_REQ -> Fault=1 and AnalogPower=0 after 16 cycles; "o" -> SHUTDOWN, then OFF after SHUT_CYC.
- Sleep/wake: Sleep=1 in SAMPLING -> RegOp=2 write; done -> SLEEP; WakeUp=1 -> WAKE for WAKE_CYC cycles -> RegOp=1 -> SAMPLING.
- Simultaneous events: "S" and OutToADCEnable=0 in the same cycle in SAMPLING -> SHUTDOWN. Reset asserted mid-write -> State=0 and all outputs 0 next cycle.
- AUTO_CAL_EN build: "O" only -> reaches SAMPLING with no further commands.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC power sequencer: state encodings, register
// write operation codes, command bytes and small decode helpers.
package adc_seq_pkg;

   localparam logic [3:0] ST_OFF       = 4'd0;
   localparam logic [3:0] ST_ADC_WARM  = 4'd1;
   localparam logic [3:0] ST_ANA_WARM  = 4'd2;
   localparam logic [3:0] ST_INIT_WR   = 4'd3;
   localparam logic [3:0] ST_INIT_IDLE = 4'd4;
   localparam logic [3:0] ST_CAL_REQ   = 4'd5;
   localparam logic [3:0] ST_CAL       = 4'd6;
   localparam logic [3:0] ST_DES_EN    = 4'd7;
   localparam logic [3:0] ST_SAMPLING  = 4'd8;
   localparam logic [3:0] ST_DIS_SLEEP = 4'd9;
   localparam logic [3:0] ST_SLEEP     = 4'd10;
   localparam logic [3:0] ST_WAKE      = 4'd11;
   localparam logic [3:0] ST_DIS_CAL   = 4'd12;
   localparam logic [3:0] ST_SHUTDOWN  = 4'd13;
   localparam logic [3:0] ST_FAULT     = 4'd14;

   localparam logic [1:0] REGOP_INIT    = 2'd0;
   localparam logic [1:0] REGOP_DES_EN  = 2'd1;
   localparam logic [1:0] REGOP_DES_DIS = 2'd2;

   localparam logic [7:0] CMD_ON    = 8'h4F;  // "O"
   localparam logic [7:0] CMD_OFF   = 8'h6F;  // "o"
   localparam logic [7:0] CMD_CAL   = 8'h43;  // "C"
   localparam logic [7:0] CMD_DES   = 8'h4E;  // "N"
   localparam logic [7:0] CMD_SLEEP = 8'h53;  // "S"
   localparam logic [7:0] CMD_WAKE  = 8'h57;  // "W"

   // States in which a register write is being requested from the serial writer
   function automatic logic isWriteState(input logic [3:0] s);
      return (s == ST_INIT_WR) || (s == ST_DES_EN) ||
             (s == ST_DIS_SLEEP) || (s == ST_DIS_CAL);
   endfunction

   // Operation code presented to the serial writer for a given write state
   function automatic logic [1:0] regOpFor(input logic [3:0] s);
      logic [1:0] op;
      case (s)
         ST_INIT_WR: op = REGOP_INIT;
         ST_DES_EN:  op = REGOP_DES_EN;
         default:    op = REGOP_DES_DIS;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// Shared delay/timeout counter for the ADC power sequencer. Counts up once per
// cycle, clears synchronously, saturates at all-ones and flags when the count
// equals the supplied terminal value.
import adc_seq_pkg::*;

module adc_seq_timer #(
   parameter int TIMER_W = 24
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               clear,
   input  logic [TIMER_W-1:0] termValue,
   output logic               terminal
);

   logic [TIMER_W-1:0] count;

   // Count up within a state, restart on clear, hold at the top instead of wrapping
   always_ff @(posedge Clock) begin
      if (Reset || clear)
         count <= '0;
      else if (count != '1)
         count <= count + 1'b1;
   end

   assign terminal = (count == termValue);

endmodule

// File: rtl/adc_power_sequencer.sv
// ADC power, calibration and DES sequencer. Drives supply enables, the CAL pin
// and register-write requests to an external serial writer.
// Optional build macro AUTO_CAL_EN: calibration starts and finishes without the
// "C"/"N" commands (the commands are still honoured).
import adc_seq_pkg::*;

module adc_power_sequencer #(
   parameter int TIMER_W      = 24,
   parameter int ADC_WARM_CYC = 256,
   parameter int ANA_WARM_CYC = 8388608,
   parameter int WAKE_CYC     = 128,
   parameter int SHUT_CYC     = 256,
   parameter int TIMEOUT_CYC  = 1048576
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] Cmd,
   input  logic       NewCmd,
   input  logic       OutToADCEnable,
   input  logic       Sleep,
   input  logic       WakeUp,
   input  logic       InCalRunning,
   input  logic       RegWriteDone,
   output logic       RegReq,
   output logic [1:0] RegOp,
   output logic       ADCPower,
   output logic       AnalogPower,
   output logic       OutCal,
   output logic [3:0] State,
   output logic       Ready,
   output logic       Fault
);

   localparam logic [TIMER_W-1:0] ADC_WARM_TERM = TIMER_W'(ADC_WARM_CYC - 1);
   localparam logic [TIMER_W-1:0] ANA_WARM_TERM = TIMER_W'(ANA_WARM_CYC - 1);
   localparam logic [TIMER_W-1:0] WAKE_TERM     = TIMER_W'(WAKE_CYC - 1);
   localparam logic [TIMER_W-1:0] SHUT_TERM     = TIMER_W'(SHUT_CYC - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_TERM  = TIMER_W'(TIMEOUT_CYC - 1);

   logic [3:0]         state;
   logic [3:0]         stateNext;
   logic               stateChange;
   logic [TIMER_W-1:0] termValue;
   logic               timerTerm;
   logic               calEnded;

   logic cmdOn, cmdOff, cmdCal, cmdDes, cmdSleep, cmdWake;

   assign cmdOn    = NewCmd && (Cmd == CMD_ON);
   assign cmdOff   = NewCmd && (Cmd == CMD_OFF);
   assign cmdCal   = NewCmd && (Cmd == CMD_CAL);
   assign cmdDes   = NewCmd && (Cmd == CMD_DES);
   assign cmdSleep = NewCmd && (Cmd == CMD_SLEEP);
   assign cmdWake  = NewCmd && (Cmd == CMD_WAKE);

   assign stateChange = (stateNext != state);

   // Pick the terminal count for the current state: fixed delays for the
   // warm-up/wake/shutdown states, the handshake timeout everywhere else
   always_comb begin
      termValue = TIMEOUT_TERM;
      case (state)
         ST_ADC_WARM:  termValue = ADC_WARM_TERM;
         ST_ANA_WARM:  termValue = ANA_WARM_TERM;
         ST_INIT_IDLE: termValue = WAKE_TERM;
         ST_WAKE:      termValue = WAKE_TERM;
         ST_SHUTDOWN:  termValue = SHUT_TERM;
         default:      termValue = TIMEOUT_TERM;
      endcase
   end

   adc_seq_timer #(
      .TIMER_W(TIMER_W)
   ) timer (
      .Clock    (Clock),
      .Reset    (Reset),
      .clear    (stateChange),
      .termValue(termValue),
      .terminal (timerTerm)
   );

   // Next-state decision; losing board permission overrides everything except
   // in the states that are already unpowered or powering down
   always_comb begin
      stateNext = state;
      case (state)
         ST_OFF:       if (cmdOn) stateNext = ST_ADC_WARM;
         ST_ADC_WARM:  if (timerTerm) stateNext = ST_ANA_WARM;
         ST_ANA_WARM:  if (timerTerm) stateNext = ST_INIT_WR;
         ST_INIT_WR: begin
            if (RegWriteDone)   stateNext = ST_INIT_IDLE;
            else if (timerTerm) stateNext = ST_FAULT;
         end
         ST_INIT_IDLE: begin
            if (cmdCal) stateNext = ST_CAL_REQ;
`ifdef AUTO_CAL_EN
            else if (timerTerm) stateNext = ST_CAL_REQ;
`endif
         end
         ST_CAL_REQ: begin
            if (InCalRunning)   stateNext = ST_CAL;
            else if (timerTerm) stateNext = ST_FAULT;
         end
         ST_CAL: begin
            if (!InCalRunning && cmdDes) stateNext = ST_DES_EN;
`ifdef AUTO_CAL_EN
            else if (calEnded && !InCalRunning) stateNext = ST_DES_EN;
`endif
            else if (InCalRunning && !calEnded && timerTerm) stateNext = ST_FAULT;
         end
         ST_DES_EN: begin
            if (RegWriteDone)   stateNext = ST_SAMPLING;
            else if (timerTerm) stateNext = ST_FAULT;
         end
         ST_SAMPLING: begin
            if (cmdOff || !OutToADCEnable) stateNext = ST_SHUTDOWN;
            else if (cmdSleep || Sleep)    stateNext = ST_DIS_SLEEP;
            else if (cmdCal)               stateNext = ST_DIS_CAL;
         end
         ST_DIS_SLEEP: begin
            if (RegWriteDone)   stateNext = ST_SLEEP;
            else if (timerTerm) stateNext = ST_FAULT;
         end
         ST_SLEEP: begin
            if (cmdOff || !OutToADCEnable) stateNext = ST_SHUTDOWN;
            else if (cmdWake || WakeUp)    stateNext = ST_WAKE;
         end
         ST_WAKE:      if (timerTerm) stateNext = ST_DES_EN;
         ST_DIS_CAL: begin
            if (RegWriteDone)   stateNext = ST_CAL_REQ;
            else if (timerTerm) stateNext = ST_FAULT;
         end
         ST_SHUTDOWN:  if (timerTerm) stateNext = ST_OFF;
         ST_FAULT:     if (cmdOff || !OutToADCEnable || cmdOn) stateNext = ST_SHUTDOWN;
         default:      stateNext = ST_SHUTDOWN;
      endcase
      if (!OutToADCEnable && (state != ST_OFF) && (state != ST_ADC_WARM) &&
          (state != ST_SHUTDOWN))
         stateNext = ST_SHUTDOWN;
   end

   // State register
   always_ff @(posedge Clock) begin
      if (Reset)
         state <= ST_OFF;
      else
         state <= stateNext;
   end

   // Remember that calibration finished so CAL stops timing out and can wait
   // indefinitely for the DES enable command
   always_ff @(posedge Clock) begin
      if (Reset || stateChange)
         calEnded <= 1'b0;
      else if ((state == ST_CAL) && !InCalRunning)
         calEnded <= 1'b1;
   end

   // Registered outputs decoded from the next state so they line up with State;
   // RegOp only updates when a write is requested so it stays stable meanwhile
   always_ff @(posedge Clock) begin
      if (Reset) begin
         RegReq      <= 1'b0;
         RegOp       <= REGOP_INIT;
         ADCPower    <= 1'b0;
         AnalogPower <= 1'b0;
         OutCal      <= 1'b0;
         Ready       <= 1'b0;
         Fault       <= 1'b0;
      end else begin
         RegReq      <= isWriteState(stateNext);
         if (isWriteState(stateNext))
            RegOp    <= regOpFor(stateNext);
         ADCPower    <= (stateNext != ST_OFF);
         AnalogPower <= OutToADCEnable && (stateNext != ST_OFF) &&
                        (stateNext != ST_ADC_WARM) && (stateNext != ST_SHUTDOWN) &&
                        (stateNext != ST_FAULT);
         OutCal      <= (stateNext == ST_CAL_REQ);
         Ready       <= (stateNext == ST_SAMPLING);
         Fault       <= (stateNext == ST_FAULT);
      end
   end

   assign State = state;

endmodule

// File: tb/tb_adc_power_sequencer.sv
// Directed testbench for adc_power_sequencer with shortened delays.
import adc_seq_pkg::*;

module tb_adc_power_sequencer;

   logic       Clock;
   logic       Reset;
   logic [7:0] Cmd;
   logic       NewCmd;
   logic       OutToADCEnable;
   logic       Sleep;
   logic       WakeUp;
   logic       InCalRunning;
   logic       RegWriteDone;
   logic       RegReq;
   logic [1:0] RegOp;
   logic       ADCPower;
   logic       AnalogPower;
   logic       OutCal;
   logic [3:0] State;
   logic       Ready;
   logic       Fault;

   int assertCount = 0;
   int failCount   = 0;

   adc_power_sequencer #(
      .TIMER_W(24),
      .ADC_WARM_CYC(4),
      .ANA_WARM_CYC(8),
      .WAKE_CYC(5),
      .SHUT_CYC(6),
      .TIMEOUT_CYC(16)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Cmd(Cmd), .NewCmd(NewCmd),
      .OutToADCEnable(OutToADCEnable), .Sleep(Sleep), .WakeUp(WakeUp),
      .InCalRunning(InCalRunning), .RegWriteDone(RegWriteDone),
      .RegReq(RegReq), .RegOp(RegOp), .ADCPower(ADCPower),
      .AnalogPower(AnalogPower), .OutCal(OutCal), .State(State),
      .Ready(Ready), .Fault(Fault)
   );

   // Free-running clock
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic pulseCmd(input logic [7:0] c);
      Cmd = c;
      NewCmd = 1'b1;
      tick();
      NewCmd = 1'b0;
      Cmd = 8'h00;
   endtask

   task automatic pulseDone();
      RegWriteDone = 1'b1;
      tick();
      RegWriteDone = 1'b0;
   endtask

   task automatic bringToSampling();
      pulseCmd(CMD_ON);
      repeat (12) tick();
      pulseDone();
      pulseCmd(CMD_CAL);
      InCalRunning = 1'b1;
      tick();
      InCalRunning = 1'b0;
      tick();
      pulseCmd(CMD_DES);
      pulseDone();
   endtask

   task automatic test_reset();
      tick();
      assertCount++;
      if (State !== 4'd0 || ADCPower !== 1'b0 || AnalogPower !== 1'b0 || RegReq !== 1'b0 ||
          RegOp !== 2'd0 || OutCal !== 1'b0 || Ready !== 1'b0 || Fault !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_outputs: got state=%0d adc=%b ana=%b req=%b op=%0d cal=%b rdy=%b flt=%b, expected all 0",
                  State, ADCPower, AnalogPower, RegReq, RegOp, OutCal, Ready, Fault);
      end
      pulseCmd(8'h58);
      pulseCmd(CMD_CAL);
      pulseDone();
      assertCount++;
      if (State !== ST_OFF || ADCPower !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL off_ignores_cmds: got state=%0d adc=%b, expected 0 0", State, ADCPower);
      end
   endtask

   task automatic test_bringup();
      pulseCmd(CMD_ON);
      assertCount++;
      if (State !== ST_ADC_WARM || ADCPower !== 1'b1 || AnalogPower !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL bringup_adc_on: got state=%0d adc=%b ana=%b, expected 1 1 0", State, ADCPower, AnalogPower);
      end
      repeat (3) tick();
      assertCount++;
      if (State !== ST_ADC_WARM || AnalogPower !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL bringup_adc_warm_end: got state=%0d ana=%b, expected 1 0", State, AnalogPower);
      end
      tick();
      assertCount++;
      if (State !== ST_ANA_WARM || AnalogPower !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL bringup_ana_on: got state=%0d ana=%b, expected 2 1", State, AnalogPower);
      end
      repeat (7) tick();
      assertCount++;
      if (State !== ST_ANA_WARM || RegReq !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL bringup_ana_warm_end: got state=%0d req=%b, expected 2 0", State, RegReq);
      end
      tick();
      assertCount++;
      if (State !== ST_INIT_WR || RegReq !== 1'b1 || RegOp !== REGOP_INIT) begin
         failCount++;
         $display("[TB] FAIL bringup_init_req: got state=%0d req=%b op=%0d, expected 3 1 0", State, RegReq, RegOp);
      end
      pulseDone();
      assertCount++;
      if (State !== ST_INIT_IDLE || RegReq !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL bringup_init_done: got state=%0d req=%b, expected 4 0", State, RegReq);
      end
      pulseDone();
      assertCount++;
      if (State !== ST_INIT_IDLE) begin
         failCount++;
         $display("[TB] FAIL stray_done_ignored: got state=%0d, expected 4", State);
      end
   endtask

   task automatic test_calibration();
      pulseCmd(CMD_CAL);
      assertCount++;
      if (State !== ST_CAL_REQ || OutCal !== 1'b1 || RegReq !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL cal_request: got state=%0d cal=%b req=%b, expected 5 1 0", State, OutCal, RegReq);
      end
      InCalRunning = 1'b1;
      tick();
      assertCount++;
      if (State !== ST_CAL || OutCal !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL cal_running: got state=%0d cal=%b, expected 6 0", State, OutCal);
      end
      pulseCmd(CMD_DES);
      repeat (8) tick();
      InCalRunning = 1'b0;
      tick();
      assertCount++;
      if (State !== ST_CAL) begin
         failCount++;
         $display("[TB] FAIL cal_waits_for_n: got state=%0d, expected 6", State);
      end
      pulseCmd(CMD_DES);
      assertCount++;
      if (State !== ST_DES_EN || RegReq !== 1'b1 || RegOp !== REGOP_DES_EN) begin
         failCount++;
         $display("[TB] FAIL des_enable_req: got state=%0d req=%b op=%0d, expected 7 1 1", State, RegReq, RegOp);
      end
      pulseDone();
      assertCount++;
      if (State !== ST_SAMPLING || Ready !== 1'b1 || RegReq !== 1'b0 || AnalogPower !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL sampling_ready: got state=%0d rdy=%b req=%b ana=%b, expected 8 1 0 1", State, Ready, RegReq, AnalogPower);
      end
   endtask

   task automatic test_sleep_wake();
      Sleep = 1'b1;
      tick();
      Sleep = 1'b0;
      assertCount++;
      if (State !== ST_DIS_SLEEP || RegReq !== 1'b1 || RegOp !== REGOP_DES_DIS || Ready !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL sleep_disable_req: got state=%0d req=%b op=%0d rdy=%b, expected 9 1 2 0", State, RegReq, RegOp, Ready);
      end
      pulseDone();
      assertCount++;
      if (State !== ST_SLEEP || RegReq !== 1'b0 || AnalogPower !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL sleep_entered: got state=%0d req=%b ana=%b, expected 10 0 1", State, RegReq, AnalogPower);
      end
      WakeUp = 1'b1;
      tick();
      WakeUp = 1'b0;
      repeat (4) tick();
      assertCount++;
      if (State !== ST_WAKE || RegReq !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL wake_delay: got state=%0d req=%b, expected 11 0", State, RegReq);
      end
      tick();
      assertCount++;
      if (State !== ST_DES_EN || RegReq !== 1'b1 || RegOp !== REGOP_DES_EN) begin
         failCount++;
         $display("[TB] FAIL wake_des_enable: got state=%0d req=%b op=%0d, expected 7 1 1", State, RegReq, RegOp);
      end
      pulseDone();
      assertCount++;
      if (State !== ST_SAMPLING || Ready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL wake_sampling: got state=%0d rdy=%b, expected 8 1", State, Ready);
      end
   endtask

   task automatic test_timeout();
      pulseCmd(CMD_CAL);
      assertCount++;
      if (State !== ST_DIS_CAL || RegReq !== 1'b1 || RegOp !== REGOP_DES_DIS) begin
         failCount++;
         $display("[TB] FAIL recal_disable_req: got state=%0d req=%b op=%0d, expected 12 1 2", State, RegReq, RegOp);
      end
      pulseDone();
      repeat (15) tick();
      assertCount++;
      if (State !== ST_CAL_REQ || Fault !== 1'b0 || OutCal !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL timeout_not_yet: got state=%0d flt=%b cal=%b, expected 5 0 1", State, Fault, OutCal);
      end
      tick();
      assertCount++;
      if (State !== ST_FAULT || Fault !== 1'b1 || AnalogPower !== 1'b0 || ADCPower !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL timeout_fault: got state=%0d flt=%b ana=%b adc=%b, expected 14 1 0 1", State, Fault, AnalogPower, ADCPower);
      end
      pulseCmd(CMD_OFF);
      repeat (5) tick();
      assertCount++;
      if (State !== ST_SHUTDOWN || ADCPower !== 1'b1 || Fault !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL shutdown_delay: got state=%0d adc=%b flt=%b, expected 13 1 0", State, ADCPower, Fault);
      end
      tick();
      assertCount++;
      if (State !== ST_OFF || ADCPower !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL shutdown_off: got state=%0d adc=%b, expected 0 0", State, ADCPower);
      end
   endtask

   task automatic test_simultaneous();
      bringToSampling();
      assertCount++;
      if (State !== ST_SAMPLING) begin
         failCount++;
         $display("[TB] FAIL resample_reached: got state=%0d, expected 8", State);
      end
      Cmd = CMD_SLEEP;
      NewCmd = 1'b1;
      OutToADCEnable = 1'b0;
      tick();
      NewCmd = 1'b0;
      assertCount++;
      if (State !== ST_SHUTDOWN || AnalogPower !== 1'b0 || RegReq !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL sleep_vs_disable: got state=%0d ana=%b req=%b, expected 13 0 0", State, AnalogPower, RegReq);
      end
      repeat (6) tick();
      OutToADCEnable = 1'b1;
      assertCount++;
      if (State !== ST_OFF) begin
         failCount++;
         $display("[TB] FAIL forced_shutdown_off: got state=%0d, expected 0", State);
      end
      pulseCmd(CMD_ON);
      repeat (12) tick();
      assertCount++;
      if (State !== ST_INIT_WR || RegReq !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL midwrite_reached: got state=%0d req=%b, expected 3 1", State, RegReq);
      end
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      assertCount++;
      if (State !== 4'd0 || ADCPower !== 1'b0 || AnalogPower !== 1'b0 || RegReq !== 1'b0 ||
          RegOp !== 2'd0 || OutCal !== 1'b0 || Ready !== 1'b0 || Fault !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_midwrite: got state=%0d adc=%b ana=%b req=%b op=%0d, expected all 0",
                  State, ADCPower, AnalogPower, RegReq, RegOp);
      end
   endtask

   task automatic test_auto_cal();
      int calCnt = 0;
      bit reached = 1'b0;
      bit sawCal = 1'b0;
      pulseCmd(CMD_ON);
      for (int i = 0; i < 200 && !reached; i++) begin
         RegWriteDone = RegReq && !RegWriteDone;
         if (OutCal) sawCal = 1'b1;
         if (State == ST_CAL_REQ) InCalRunning = 1'b1;
         if (State == ST_CAL) begin
            calCnt++;
            if (calCnt >= 5) InCalRunning = 1'b0;
         end
         tick();
         if (State == ST_SAMPLING) reached = 1'b1;
      end
      RegWriteDone = 1'b0;
      assertCount++;
      if (!reached || Ready !== 1'b1 || !sawCal) begin
         failCount++;
         $display("[TB] FAIL auto_cal_sampling: got reached=%b rdy=%b sawCal=%b state=%0d, expected 1 1 1 8",
                  reached, Ready, sawCal, State);
      end
   endtask

   // Test sequence
   initial begin
      Reset = 1'b1;
      Cmd = 8'h00;
      NewCmd = 1'b0;
      OutToADCEnable = 1'b1;
      Sleep = 1'b0;
      WakeUp = 1'b0;
      InCalRunning = 1'b0;
      RegWriteDone = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      $display("[TB] starting directed tests");
      test_reset();
`ifdef AUTO_CAL_EN
      test_auto_cal();
`else
      test_bringup();
      test_calibration();
      test_sleep_wake();
      test_timeout();
      test_simultaneous();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
